// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding stage: descriptor field widths,
// the MAC group bit and the dispatch FSM state encoding.
package fwd_pkg;

  localparam int MAC_W     = 48;
  localparam int PORT_W    = 2;
  localparam int GROUP_BIT = 40;
  // src_port + da + sa; the two page fields are appended by the user
  localparam int FIXED_W   = PORT_W + 2 * MAC_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_DISPATCH,
    ST_DROP
  } state_e;

  function automatic logic is_group(input logic [MAC_W-1:0] mac);
    return mac[GROUP_BIT];
  endfunction

endpackage

// File: rtl/fwd_cam.sv
// Fully associative MAC -> port table with parallel DA/SA compare and a
// single learn write port that fills round-robin via repl_ptr.
module fwd_cam
  import fwd_pkg::*;
#(
  parameter int entries = 8,
  localparam int IDX_W  = $clog2(entries)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_en,
  input  logic [MAC_W-1:0]  da,
  input  logic [MAC_W-1:0]  sa,
  input  logic [PORT_W-1:0] src_port,
  output logic              da_hit,
  output logic [PORT_W-1:0] da_port
);

  logic [entries-1:0] valid_q, valid_d;
  logic [MAC_W-1:0]   mac_q  [entries];
  logic [MAC_W-1:0]   mac_d  [entries];
  logic [PORT_W-1:0]  port_q [entries];
  logic [PORT_W-1:0]  port_d [entries];
  logic [IDX_W-1:0]   repl_ptr_q, repl_ptr_d;

  logic [entries-1:0] da_match, sa_match;
  logic               sa_hit;
  logic [PORT_W-1:0]  sa_port;
  logic [IDX_W-1:0]   sa_idx;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;

  genvar gi;
  generate
    for (gi = 0; gi < entries; gi++) begin : g_cmp
      assign da_match[gi] = valid_q[gi] && (mac_q[gi] == da);
      assign sa_match[gi] = valid_q[gi] && (mac_q[gi] == sa);
    end
  endgenerate

  // Learning never creates duplicates, so at most one entry matches each key.
  always_comb begin
    da_hit  = |da_match;
    sa_hit  = |sa_match;
    da_port = '0;
    sa_port = '0;
    sa_idx  = '0;
    for (int i = 0; i < entries; i++) begin
      if (da_match[i]) da_port = port_q[i];
      if (sa_match[i]) begin
        sa_port = port_q[i];
        sa_idx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    wr_en      = 1'b0;
    wr_idx     = repl_ptr_q;
    repl_ptr_d = repl_ptr_q;
    if (lookup_en && !is_group(sa)) begin
      if (sa_hit) begin
        if (sa_port != src_port) begin
          wr_en  = 1'b1;
          wr_idx = sa_idx;
        end
      end else begin
        wr_en      = 1'b1;
        repl_ptr_d = (repl_ptr_q == IDX_W'(entries - 1)) ? '0 : repl_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    mac_d   = mac_q;
    port_d  = port_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      mac_d[wr_idx]   = sa;
      port_d[wr_idx]  = src_port;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      repl_ptr_q <= '0;
      for (int i = 0; i < entries; i++) begin
        mac_q[i]  <= '0;
        port_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      repl_ptr_q <= repl_ptr_d;
      mac_q      <= mac_d;
      port_q     <= port_d;
    end
  end

endmodule

// File: rtl/fwd_dispatch.sv
// Forwarding stage: registers one joined descriptor, learns/looks up MACs,
// then forks the start page to each destination port or requests a drop.
module fwd_dispatch
  import fwd_pkg::*;
#(
  parameter int num_ports = 4,
  parameter int entries   = 8,
  parameter int pg_asz    = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pm2f_srdy,
  output logic                          pm2f_drdy,
  input  logic [FIXED_W+2*pg_asz-1:0]   pm2f_data,
  output logic [num_ports-1:0]          f2d_srdy,
  input  logic [num_ports-1:0]          f2d_drdy,
  output logic [pg_asz-1:0]             f2d_data,
  output logic                          drp_srdy,
  input  logic                          drp_drdy,
  output logic [2*pg_asz-1:0]           drp_page_list,
  output logic [15:0]                   drop_cnt
);

  localparam int DESC_W    = FIXED_W + 2 * pg_asz;
  localparam int END_LSB   = 0;
  localparam int START_LSB = pg_asz;
  localparam int SA_LSB    = 2 * pg_asz;
  localparam int DA_LSB    = SA_LSB + MAC_W;
  localparam int SRC_LSB   = DA_LSB + MAC_W;

  state_e                 state_q, state_d;
  logic [DESC_W-1:0]      desc_q, desc_d;
  logic [num_ports-1:0]   mask_q, mask_d;
  logic [pg_asz-1:0]      f2d_data_q, f2d_data_d;
  logic                   drp_srdy_q, drp_srdy_d;
  logic [2*pg_asz-1:0]    drp_list_q, drp_list_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  logic [PORT_W-1:0]      src_port;
  logic [MAC_W-1:0]       da, sa;
  logic [pg_asz-1:0]      start_pg, end_pg;
  logic                   lookup_en;
  logic                   da_hit;
  logic [PORT_W-1:0]      da_port;
  logic [num_ports-1:0]   flood_mask, lookup_mask;

  assign src_port = desc_q[SRC_LSB +: PORT_W];
  assign da       = desc_q[DA_LSB +: MAC_W];
  assign sa       = desc_q[SA_LSB +: MAC_W];
  assign start_pg = desc_q[START_LSB +: pg_asz];
  assign end_pg   = desc_q[END_LSB +: pg_asz];

  fwd_cam #(.entries(entries)) u_cam (
    .clk      (clk),
    .reset    (reset),
    .lookup_en(lookup_en),
    .da       (da),
    .sa       (sa),
    .src_port (src_port),
    .da_hit   (da_hit),
    .da_port  (da_port)
  );

  // The table is read before this packet's learn write lands.
  always_comb begin
    flood_mask = ~(num_ports'(1) << src_port);
    if (is_group(da) || !da_hit) lookup_mask = flood_mask;
    else if (da_port == src_port) lookup_mask = '0;
    else                          lookup_mask = num_ports'(1) << da_port;
  end

  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    mask_d     = mask_q;
    f2d_data_d = f2d_data_q;
    drp_srdy_d = drp_srdy_q;
    drp_list_d = drp_list_q;
    drop_cnt_d = drop_cnt_q;
    lookup_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pm2f_srdy) begin
          desc_d  = pm2f_data;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        lookup_en = 1'b1;
        if (|lookup_mask) begin
          mask_d     = lookup_mask;
          f2d_data_d = start_pg;
          state_d    = ST_DISPATCH;
        end else begin
          drp_srdy_d = 1'b1;
          drp_list_d = {start_pg, end_pg};
          state_d    = ST_DROP;
        end
      end
      ST_DISPATCH: begin
        mask_d = mask_q & ~f2d_drdy;
        if (mask_d == '0) state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (drp_drdy) begin
          drp_srdy_d = 1'b0;
          drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      desc_q     <= '0;
      mask_q     <= '0;
      f2d_data_q <= '0;
      drp_srdy_q <= 1'b0;
      drp_list_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      desc_q     <= desc_d;
      mask_q     <= mask_d;
      f2d_data_q <= f2d_data_d;
      drp_srdy_q <= drp_srdy_d;
      drp_list_q <= drp_list_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pm2f_drdy     = (state_q == ST_IDLE);
  assign f2d_srdy      = mask_q;
  assign f2d_data      = f2d_data_q;
  assign drp_srdy      = drp_srdy_q;
  assign drp_page_list = drp_list_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_fwd_dispatch.sv
// Scoreboard bench for fwd_dispatch: a reference MAC table predicts each
// packet's outcome, which is queued at drive time and checked at cycle 2 on.
module tb_fwd_dispatch;

  localparam int NP = 4;
  localparam int NE = 8;
  localparam int PA = 12;
  localparam int DW = 98 + 2 * PA;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            pm2f_srdy = 1'b0;
  logic            pm2f_drdy;
  logic [DW-1:0]   pm2f_data = '0;
  logic [NP-1:0]   f2d_srdy;
  logic [NP-1:0]   f2d_drdy = '0;
  logic [PA-1:0]   f2d_data;
  logic            drp_srdy;
  logic            drp_drdy = 1'b0;
  logic [2*PA-1:0] drp_page_list;
  logic [15:0]     drop_cnt;

  fwd_dispatch #(.num_ports(NP), .entries(NE), .pg_asz(PA)) dut (
    .clk          (clk),
    .reset        (reset),
    .pm2f_srdy    (pm2f_srdy),
    .pm2f_drdy    (pm2f_drdy),
    .pm2f_data    (pm2f_data),
    .f2d_srdy     (f2d_srdy),
    .f2d_drdy     (f2d_drdy),
    .f2d_data     (f2d_data),
    .drp_srdy     (drp_srdy),
    .drp_drdy     (drp_drdy),
    .drp_page_list(drp_page_list),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            drop;
    logic [NP-1:0]   mask;
    logic [PA-1:0]   data;
    logic [2*PA-1:0] pages;
  } exp_t;

  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // reference table
  logic        m_valid [NE];
  logic [47:0] m_mac   [NE];
  logic [1:0]  m_port  [NE];
  int          m_ptr;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0;
      m_mac[i]   = '0;
      m_port[i]  = '0;
    end
    m_ptr = 0;
    m_cnt = '0;
  endtask

  function automatic logic [NP-1:0] model_lookup(input logic [1:0] src,
                                                 input logic [47:0] da,
                                                 input logic [47:0] sa);
    logic          hit = 1'b0;
    logic [1:0]    p = '0;
    int            shit = -1;
    logic [NP-1:0] flood;
    logic [NP-1:0] m;
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_mac[i] == da) begin
        hit = 1'b1;
        p   = m_port[i];
      end
    flood = 4'hF & ~(4'b0001 << src);
    if (da[40] || !hit) m = flood;
    else if (p == src)  m = '0;
    else                m = 4'b0001 << p;
    if (!sa[40]) begin
      for (int i = 0; i < NE; i++)
        if (m_valid[i] && m_mac[i] == sa) shit = i;
      if (shit >= 0) m_port[shit] = src;
      else begin
        m_valid[m_ptr] = 1'b1;
        m_mac[m_ptr]   = sa;
        m_port[m_ptr]  = src;
        m_ptr          = (m_ptr + 1) % NE;
      end
    end
    return m;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  // dN = cycles after first srdy before port N's drdy rises; dd likewise for drop.
  task automatic run_pkt(input logic [1:0] src, input logic [47:0] da, input logic [47:0] sa,
                         input logic [PA-1:0] st, input logic [PA-1:0] en,
                         input int d0, input int d1, input int d2, input int d3, input int dd);
    exp_t          e;
    logic [NP-1:0] pend;
    int            dly[NP];
    int            c;
    logic          hs;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    chk("idle_drdy", pm2f_drdy, 1);
    pm2f_srdy = 1'b1;
    pm2f_data = {src, da, sa, st, en};
    e.mask  = model_lookup(src, da, sa);
    e.drop  = (e.mask == '0);
    e.data  = st;
    e.pages = {st, en};
    sb_q.push_back(e);
    @(negedge clk);
    pm2f_srdy = 1'b0;
    chk("lookup_drdy", pm2f_drdy, 0);
    chk("lookup_f2d", f2d_srdy, 0);
    chk("lookup_drp", drp_srdy, 0);
    @(negedge clk);
    e = sb_q.pop_front();
    if (!e.drop) begin
      pend = e.mask;
      c    = 0;
      while (pend != '0 && c < 50) begin
        chk("f2d_srdy", f2d_srdy, pend);
        chk("f2d_data", f2d_data, e.data);
        chk("disp_drp", drp_srdy, 0);
        for (int p = 0; p < NP; p++) f2d_drdy[p] = (c >= dly[p]);
        pend = pend & ~f2d_drdy;
        @(negedge clk);
        c++;
      end
      f2d_drdy = '0;
      chk("f2d_pend", pend, 0);
      chk("f2d_done", f2d_srdy, 0);
    end else begin
      hs = 1'b0;
      c  = 0;
      while (!hs && c < 50) begin
        chk("drp_srdy", drp_srdy, 1);
        chk("drp_list", drp_page_list, e.pages);
        chk("drop_f2d", f2d_srdy, 0);
        drp_drdy = (c >= dd);
        hs       = drp_drdy;
        @(negedge clk);
        c++;
      end
      drp_drdy = 1'b0;
      if (hs && m_cnt != 16'hFFFF) m_cnt++;
      chk("drp_hs", hs, 1);
      chk("drp_done", drp_srdy, 0);
    end
    chk("drop_cnt", drop_cnt, m_cnt);
    chk("back_idle", pm2f_drdy, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_drdy", pm2f_drdy, 1);
    chk("rst_f2d", f2d_srdy, 0);
    chk("rst_drp", drp_srdy, 0);
    chk("rst_f2d_data", f2d_data, 0);
    chk("rst_list", drp_page_list, 0);
    chk("rst_cnt", drop_cnt, 0);
    chk("rst_valid", dut.u_cam.valid_q, 0);

    // empty-table flood, all ports accept at once
    run_pkt(2'd0, 48'h0A00_0000_0001, 48'h0B00_0000_0001, 12'd5, 12'd9, 0, 0, 0, 0, 0);
    // learned unicast
    run_pkt(2'd2, 48'h0B00_0000_0001, 48'h0C00_0000_0002, 12'd7, 12'd8, 0, 0, 0, 0, 0);
    // unicast back to source port -> drop
    run_pkt(2'd0, 48'h0B00_0000_0001, 48'h0D00_0000_0003, 12'd5, 12'd9, 0, 0, 0, 0, 2);
    // broadcast with staggered accepts; port0 drdy is not part of the mask
    run_pkt(2'd0, 48'hFFFF_FFFF_FFFF, 48'h0B00_0000_0001, 12'd5, 12'd9, 0, 0, 4, 2, 0);
    // SA moves to port 3, then unicast follows it
    run_pkt(2'd3, 48'h0100_0000_0000, 48'h0B00_0000_0001, 12'd1, 12'd2, 1, 0, 0, 0, 0);
    run_pkt(2'd0, 48'h0B00_0000_0001, 48'h0E00_0000_0004, 12'd3, 12'd4, 0, 0, 0, 3, 0);
    // DA == SA, both unknown -> flood
    run_pkt(2'd1, 48'h0600_0000_0006, 48'h0600_0000_0006, 12'd6, 12'd6, 0, 0, 0, 0, 0);
    // group SA is never learned, so it floods as DA afterwards
    run_pkt(2'd2, 48'h0100_0000_0000, 48'h0F00_0000_0007, 12'd8, 12'd9, 0, 0, 0, 0, 0);
    run_pkt(2'd1, 48'h0F00_0000_0007, 48'h1000_0000_0008, 12'd8, 12'd9, 0, 0, 0, 0, 0);

    // reset in the first DISPATCH cycle
    pm2f_srdy = 1'b1;
    pm2f_data = {2'd0, 48'hFFFF_FFFF_FFFF, 48'h0B00_0000_0001, 12'd5, 12'd9};
    @(negedge clk);
    pm2f_srdy = 1'b0;
    @(negedge clk);
    chk("pre_rst_f2d", f2d_srdy, 4'b1110);
    reset = 1'b0;
    #1;
    chk("mid_rst_f2d", f2d_srdy, 0);
    chk("mid_rst_drp", drp_srdy, 0);
    chk("mid_rst_valid", dut.u_cam.valid_q, 0);
    chk("mid_rst_cnt", drop_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_drdy", pm2f_drdy, 1);
    chk("post_rst_drp", drp_srdy, 0);

    // nine distinct SAs into an eight-entry table
    for (int i = 0; i < 9; i++)
      run_pkt(2'(i % 4), 48'h0100_0000_0000, 48'h0200_0000_0000 + 48'(i),
              12'(i), 12'(i + 1), 0, 0, 0, 0, 0);
    chk("repl_ptr", dut.u_cam.repl_ptr_q, 1);
    run_pkt(2'd1, 48'h0200_0000_0000, 48'h0300_0000_0001, 12'd10, 12'd11, 0, 0, 0, 0, 0);
    run_pkt(2'd3, 48'h0200_0000_0001, 48'h0300_0000_0002, 12'd12, 12'd13, 0, 0, 0, 0, 0);
    run_pkt(2'd1, 48'h0200_0000_0001, 48'h0300_0000_0003, 12'd14, 12'd15, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
